fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer for the 16-bit single-issue pipeline. Owns the architectural PC register and decides every cycle whether it advances by 2, takes a branch redirect, holds for a hazard stall, waits on an instruction-cache miss, or freezes on HLT. It sits between the I-cache port, the decode-stage branch resolver (branch_taken/target) and the hazard unit, and tells the IF/ID register whether the fetched word is valid.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall: hold PC, invalidate fetch.
- redirect  in  1  branch taken, resolved in decode this cycle.
- redirect_pc  in  16  branch target; bit 0 ignored (forced 0).
- halt_dec  in  1  fetched word is HLT (qualified by icache_rdy).
- icache_rdy  in  1  instruction word for pc valid this cycle.
- icache_req  out  1  fetch request for address pc.
- pc  out  16  current fetch address.
- pc_plus2  out  16  pc + 2 (mod 2^16), forwarded to IF/ID.
- if_valid  out  1  fetched word is to be latched into IF/ID; 0 means insert NOP.
- halted  out  1  core halted.

## Operation
- States: BOOT, RUN, MISS, MISS_REDIR, HALT. Registers: state, pc, pend_pc (16).
- Priority within a cycle: reset > stall > redirect > halt_dec > normal advance.
- BOOT: icache_req=0, if_valid=0; next state RUN unconditionally.
- RUN, icache_req=1:
  - rdy=1, no stall, redirect: pc<=redirect_pc, if_valid=0, stay RUN.
  - rdy=1, no stall, no redirect, halt_dec: if_valid=1 (HLT enters IF/ID), pc holds, -> HALT.
  - rdy=1, no stall, otherwise: if_valid=1, pc<=pc+2, stay RUN.
  - rdy=0: -> MISS. If redirect and no stall, also pend_pc<=redirect_pc, -> MISS_REDIR instead.
- MISS, icache_req=1: rdy=0 waits; redirect without stall latches pend_pc, -> MISS_REDIR. rdy=1 applies the RUN rdy=1 rules, then -> RUN (or HALT).
- MISS_REDIR, icache_req=1, if_valid=0: the in-flight fill cannot be aborted. A new redirect without stall overwrites pend_pc (last wins). On rdy=1 the word is discarded, pc<=pend_pc, -> RUN.
- HALT: icache_req=0, if_valid=0, halted=1, pc frozen; exits only via rst_n.
- stall=1: pc and pend_pc hold, if_valid=0, redirect and halt_dec ignored (hazard unit re-presents them). Miss tracking continues: RUN with rdy=0 -> MISS; MISS with rdy=1 -> RUN with pc unchanged (re-fetch hits).
- Arithmetic: pc+2 wraps 16'hFFFE -> 16'h0000; pc[0] always 0.

## Timing
- Reset (rst_n low, async): state=BOOT, pc=RESET_PC, pend_pc=0, icache_req=0, if_valid=0, halted=0, pc_plus2=RESET_PC+2.
- First fetch request in the 2nd cycle after rst_n rises, one-cycle boot bubble.
- pc, state and pend_pc update on rising clk. icache_req, if_valid, halted and pc_plus2 are combinational from state/pc/inputs, valid in the same cycle.
- Hit stream: one instruction per cycle, if_valid=1 continuously.
- Taken branch: exactly one bubble (if_valid=0 in redirect cycle); target fetched next cycle.
- Miss of N cycles: N cycles if_valid=0, word accepted in the rdy cycle.
- rst_n asserted in any state, including MISS_REDIR mid-fill, returns to BOOT immediately; pend_pc discarded.

## Test plan
- Reset RESET_PC=16'h0040, rdy tied 1: cycle 1 icache_req=0; cycles 2-5 pc=0040,0042,0044,0046, if_valid=1 each.
- pc=16'h0010, redirect=1, redirect_pc=16'h0101, rdy=1 -> if_valid=0 that cycle; next cycle pc=16'h0100, if_valid=1.
- pc=16'h0020, rdy=0 for 3 cycles with redirect to 16'h0200 in cycle 2 -> if_valid=0 for 4 cycles; rdy cycle discarded; next pc=16'h0200.
- stall=1 and redirect=1 together at pc=16'h0030 -> pc stays 16'h0030, if_valid=0; stall drops, redirect re-presented -> pc=target.
- halt_dec=1 with rdy=1 at pc=16'h0050 -> if_valid=1 once; then halted=1, icache_req=0, pc=16'h0050 for 10+ cycles; same-cycle redirect instead suppresses halt.
- pc=16'hFFFE, rdy=1 -> pc wraps to 16'h0000, pc_plus2=16'h0002; async rst_n pulse mid-MISS_REDIR -> pc=RESET_PC, state BOOT without clock edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the architectural PC and arbitrates between
// sequential advance, branch redirect, hazard stall, I-cache miss and HLT.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_dec,
    input  logic        icache_rdy,
    output logic        icache_req,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        if_valid,
    output logic        halted
);

    localparam logic [2:0] S_BOOT       = 3'd0;
    localparam logic [2:0] S_RUN        = 3'd1;
    localparam logic [2:0] S_MISS       = 3'd2;
    localparam logic [2:0] S_MISS_REDIR = 3'd3;
    localparam logic [2:0] S_HALT       = 3'd4;

    localparam logic [15:0] PC_MASK  = 16'hFFFE;
    localparam logic [15:0] RST_ADDR = RESET_PC & PC_MASK;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] tgt;
    logic [15:0] pc_inc;
    logic        take_redir;

    assign tgt        = redirect_pc & PC_MASK;
    assign pc_inc     = pc_q + 16'd2;
    assign take_redir = redirect && !stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        icache_req = 1'b0;
        if_valid   = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_MISS: begin
                icache_req = 1'b1;
                if (!icache_rdy) begin
                    state_d = S_MISS;
                    if (take_redir) begin
                        pend_d  = tgt;
                        state_d = S_MISS_REDIR;
                    end
                end else if (stall) begin
                    // word arrived but is dropped; re-fetch will hit
                    state_d = S_RUN;
                end else if (redirect) begin
                    pc_d    = tgt;
                    state_d = S_RUN;
                end else if (halt_dec) begin
                    if_valid = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    if_valid = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = S_RUN;
                end
            end
            S_MISS_REDIR: begin
                // fill in flight belongs to the wrong path; wait, then drop it
                icache_req = 1'b1;
                if (!stall) begin
                    if (redirect) begin
                        pend_d = tgt;
                    end
                    if (icache_rdy) begin
                        pc_d    = redirect ? tgt : pend_q;
                        state_d = S_RUN;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RST_ADDR;
            pend_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus2 = pc_inc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded directed bench for fetch_ctrl: stimulus queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_dec;
    logic        icache_rdy;
    logic        icache_req;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        if_valid;
    logic        halted;

    fetch_ctrl #(.RESET_PC(16'h0040)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt_dec(halt_dec),
        .icache_rdy(icache_rdy),
        .icache_req(icache_req),
        .pc(pc),
        .pc_plus2(pc_plus2),
        .if_valid(if_valid),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [34:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // {pc, pc_plus2, icache_req, if_valid, halted}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [34:0] e;
            logic [34:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pc, pc_plus2, icache_req, if_valid, halted};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h p2=%h req=%b val=%b hlt=%b want pc=%h p2=%h req=%b val=%b hlt=%b",
                         nm, a[34:19], a[18:3], a[2], a[1], a[0],
                         e[34:19], e[18:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic push(input string nm, input logic [15:0] p,
                        input logic rq, input logic v, input logic h);
        logic [15:0] p2;
        p2 = p + 16'd2;
        exp_q.push_back({p, p2, rq, v, h});
        name_q.push_back(nm);
    endtask

    task automatic set_in(input logic st, input logic rd,
                          input logic [15:0] rp, input logic hd,
                          input logic ry);
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        halt_dec    = hd;
        icache_rdy  = ry;
    endtask

    // one cycle: drive, queue expectation, advance to just past next posedge
    task automatic cyc(input string nm, input logic st, input logic rd,
                       input logic [15:0] rp, input logic hd,
                       input logic ry, input logic [15:0] p,
                       input logic rq, input logic v, input logic h);
        set_in(st, rd, rp, hd, ry);
        push(nm, p, rq, v, h);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 16'h0000, 0, 1);
        @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 0, 1, 16'h0040, 0, 0, 0);
        rst_n = 1'b1;
        cyc("boot", 0, 0, 0, 0, 1, 16'h0040, 0, 0, 0);
        cyc("run0", 0, 0, 0, 0, 1, 16'h0040, 1, 1, 0);
        cyc("run1", 0, 0, 0, 0, 1, 16'h0042, 1, 1, 0);
        cyc("run2", 0, 0, 0, 0, 1, 16'h0044, 1, 1, 0);
        cyc("run3", 0, 0, 0, 0, 1, 16'h0046, 1, 1, 0);
        // branch: one bubble, target bit 0 dropped
        cyc("br_to10", 0, 1, 16'h0010, 0, 1, 16'h0048, 1, 0, 0);
        cyc("br_bub", 0, 1, 16'h0101, 0, 1, 16'h0010, 1, 0, 0);
        cyc("br_tgt", 0, 0, 0, 0, 1, 16'h0100, 1, 1, 0);
        cyc("br_to20", 0, 1, 16'h0020, 0, 1, 16'h0102, 1, 0, 0);
        // miss with redirect during the fill
        cyc("miss1", 0, 0, 0, 0, 0, 16'h0020, 1, 0, 0);
        cyc("miss2r", 0, 1, 16'h0200, 0, 0, 16'h0020, 1, 0, 0);
        cyc("miss3", 0, 0, 0, 0, 0, 16'h0020, 1, 0, 0);
        cyc("miss_drop", 0, 0, 0, 0, 1, 16'h0020, 1, 0, 0);
        cyc("miss_tgt", 0, 0, 0, 0, 1, 16'h0200, 1, 1, 0);
        // stall beats redirect
        cyc("to30", 0, 1, 16'h0030, 0, 1, 16'h0202, 1, 0, 0);
        cyc("stall_br", 1, 1, 16'h0300, 0, 1, 16'h0030, 1, 0, 0);
        cyc("br_again", 0, 1, 16'h0300, 0, 1, 16'h0030, 1, 0, 0);
        cyc("stall_tgt", 0, 0, 0, 0, 1, 16'h0300, 1, 1, 0);
        // miss tracking under stall, then refetch
        cyc("st_miss", 1, 0, 0, 0, 0, 16'h0302, 1, 0, 0);
        cyc("st_fill", 1, 0, 0, 0, 1, 16'h0302, 1, 0, 0);
        cyc("refetch", 0, 0, 0, 0, 1, 16'h0302, 1, 1, 0);
        // plain miss then accepted word
        cyc("pmiss", 0, 0, 0, 0, 0, 16'h0304, 1, 0, 0);
        cyc("pmiss_ok", 0, 0, 0, 0, 1, 16'h0304, 1, 1, 0);
        // wrap at top of address space
        cyc("to_fffe", 0, 1, 16'hFFFF, 0, 1, 16'h0306, 1, 0, 0);
        cyc("wrap", 0, 0, 0, 0, 1, 16'hFFFE, 1, 1, 0);
        cyc("wrapped", 0, 0, 0, 0, 1, 16'h0000, 1, 1, 0);
        // redirect suppresses HLT in the same cycle
        cyc("hlt_redir", 0, 1, 16'h0050, 1, 1, 16'h0002, 1, 0, 0);
        cyc("hlt_word", 0, 0, 0, 1, 1, 16'h0050, 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cyc("halted", 0, i[0], 16'h0700, 1, 1, 16'h0050, 0, 0, 1);
        end
        // reset out of HALT, then async reset in MISS_REDIR
        rst_n = 1'b0;
        cyc("rst2", 0, 0, 0, 0, 1, 16'h0040, 0, 0, 0);
        rst_n = 1'b1;
        cyc("boot2", 0, 0, 0, 0, 0, 16'h0040, 0, 0, 0);
        cyc("mr_miss", 0, 0, 0, 0, 0, 16'h0040, 1, 0, 0);
        cyc("mr_redir", 0, 1, 16'h0400, 0, 0, 16'h0040, 1, 0, 0);
        cyc("mr_wait", 0, 0, 0, 0, 0, 16'h0040, 1, 0, 0);
        set_in(0, 0, 16'h0000, 0, 0);
        push("async_rst", 16'h0040, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("boot3", 0, 0, 0, 0, 1, 16'h0040, 0, 0, 0);
        cyc("no_pend", 0, 0, 0, 0, 1, 16'h0040, 1, 1, 0);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
